// File: rtl/pio_pkg.sv
// Shared definitions for the PIO command sequencer: action codes, widths and FSM states.
package pio_pkg;

  localparam int unsigned IdxW  = 5;
  localparam int unsigned NumSm = 4;

  localparam logic [3:0] ActNone  = 4'd0;
  localparam logic [3:0] ActInstr = 4'd1;
  localparam logic [3:0] ActPend  = 4'd2;
  localparam logic [3:0] ActPull  = 4'd3;
  localparam logic [3:0] ActPush  = 4'd4;
  localparam logic [3:0] ActGrps  = 4'd5;
  localparam logic [3:0] ActEn    = 4'd6;
  localparam logic [3:0] ActDiv   = 4'd7;
  localparam logic [3:0] ActShift = 4'd10;

  typedef enum logic [3:0] {
    StLdAddr,
    StLdWr,
    StCPend,
    StCDiv,
    StCGrps,
    StCShift,
    StCEn,
    StIdle,
    StPush,
    StWaitRx,
    StPull,
    StCapt,
    StResp
  } state_e;

endpackage

// File: rtl/pio_spi_host.sv
// Loads a PIO program, configures one state machine, then runs byte-wide SPI transactions
// through the PIO TX/RX FIFOs with a bounded wait for the response.
module pio_spi_host
  import pio_pkg::*;
#(
  parameter int unsigned PLEN       = 2,
  parameter int unsigned MINDEX     = 0,
  parameter logic [23:0] DIV        = 24'h000C80,
  parameter logic [31:0] PIN_GRPS   = 32'h20100001,
  parameter logic [31:0] EXEC_CTRL  = 32'h00001000,
  parameter logic [31:0] SHIFT_CTRL = 32'h10830000,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic            clk,
  input  logic            reset,
  output logic [4:0]      prog_addr,
  input  logic [15:0]     prog_data,
  input  logic            tx_valid,
  input  logic [7:0]      tx_data,
  output logic            tx_ready,
  output logic            rx_valid,
  output logic [7:0]      rx_data,
  output logic            rx_err,
  input  logic            rx_ready,
  output logic            cfg_done,
  output logic [3:0]      action,
  output logic [IdxW-1:0] index,
  output logic [1:0]      mindex,
  output logic [31:0]     din,
  input  logic [31:0]     dout,
  input  logic [NumSm-1:0] tx_full,
  input  logic [NumSm-1:0] rx_empty
);

  localparam int unsigned CntW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
  localparam logic [5:0] ProgLen = 6'(PLEN);

  state_e          state_q, state_d;
  logic [5:0]      i_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      byte_q;
  logic [7:0]      rx_data_q;
  logic            rx_err_q;
  logic            cfg_done_q;

  logic sm_tx_full, sm_rx_empty, tx_accept;
  logic unused_ok;

  assign sm_tx_full  = tx_full[MINDEX];
  assign sm_rx_empty = rx_empty[MINDEX];
  assign tx_accept   = (state_q == StIdle) && tx_valid && !sm_tx_full;
  assign unused_ok   = ^{dout[31:8], tx_full, rx_empty};

  assign mindex   = 2'(MINDEX);
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
  assign cfg_done = cfg_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLdAddr;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLdAddr: state_d = (ProgLen == 6'd0) ? StCPend : StLdWr;
      StLdWr:   state_d = ((i_q + 6'd1) < ProgLen) ? StLdAddr : StCPend;
      StCPend:  state_d = StCDiv;
      StCDiv:   state_d = StCGrps;
      StCGrps:  state_d = StCShift;
      StCShift: state_d = StCEn;
      StCEn:    state_d = StIdle;
      StIdle:   if (tx_accept) state_d = StPush;
      StPush:   state_d = StWaitRx;
      // Data arriving on the same cycle the timeout fires still takes the PULL path.
      StWaitRx: begin
        if (!sm_rx_empty) begin
          state_d = StPull;
        end else if (cnt_q == CntMax) begin
          state_d = StResp;
        end
      end
      StPull:   state_d = StCapt;
      StCapt:   state_d = StResp;
      StResp:   if (rx_ready) state_d = StIdle;
      default:  state_d = StLdAddr;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q        <= '0;
      cnt_q      <= '0;
      byte_q     <= '0;
      rx_data_q  <= '0;
      rx_err_q   <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StLdWr: i_q <= i_q + 6'd1;
        StCEn:  cfg_done_q <= 1'b1;
        StIdle: if (tx_accept) byte_q <= tx_data;
        StPush: cnt_q <= '0;
        StWaitRx: begin
          if (sm_rx_empty) begin
            if (cnt_q == CntMax) begin
              rx_err_q  <= 1'b1;
              rx_data_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StCapt: begin
          rx_data_q <= dout[7:0];
          rx_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    action    = ActNone;
    din       = '0;
    index     = '0;
    prog_addr = i_q[4:0];
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    unique case (state_q)
      StLdWr: begin
        action = ActInstr;
        index  = i_q[4:0];
        din    = {16'h0, prog_data};
      end
      StCPend:  begin action = ActPend;  din = EXEC_CTRL;     end
      StCDiv:   begin action = ActDiv;   din = {8'h0, DIV};   end
      StCGrps:  begin action = ActGrps;  din = PIN_GRPS;      end
      StCShift: begin action = ActShift; din = SHIFT_CTRL;    end
      StCEn:    begin action = ActEn;    din = 32'(1) << MINDEX; end
      StIdle:   tx_ready = !sm_tx_full;
      // Left shift with autopull at 8 consumes the byte from bit 31 down.
      StPush:   begin action = ActPush;  din = {byte_q, 24'h0}; end
      StPull:   action = ActPull;
      StResp:   rx_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pio_spi_host.sv
// Directed bench for pio_spi_host: config sequence, SPI transactions, backpressure, timeout, reset.
module tb_pio_spi_host;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic        rx_ready;
  logic        cfg_done;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  tx_full;
  logic [3:0]  rx_empty;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [31:0] din;
  } cfg_vec_t;

  typedef struct {
    logic [7:0]  data;
    int          full_cyc;
    int          delay;     // WAIT_RX cycles before data appears; negative = never
    logic [31:0] dout_v;
    int          rx_hold;
    logic [7:0]  exp_data;
    logic        exp_err;
  } txn_t;

  cfg_vec_t cfg_tab[9];
  txn_t     txn_tab[6];

  pio_spi_host #(
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .rx_ready (rx_ready),
    .cfg_done (cfg_done),
    .action   (action),
    .index    (index),
    .mindex   (mindex),
    .din      (din),
    .dout     (dout),
    .tx_full  (tx_full),
    .rx_empty (rx_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [4:0] a);
    case (a)
      5'd0:    return 16'h6001;
      5'd1:    return 16'h4001;
      default: return 16'h0000;
    endcase
  endfunction

  // Synchronous ROM: data follows the address by one cycle.
  always @(posedge clk) prog_data <= rom_word(prog_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expects reset high on entry; releases it and checks the whole configuration stream.
  task automatic do_config();
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("cfg_act[%0d]", c), 32'(action), 32'(cfg_tab[c].act));
      if (cfg_tab[c].act != ActNone) check($sformatf("cfg_din[%0d]", c), din, cfg_tab[c].din);
      if (cfg_tab[c].act == ActInstr)
        check($sformatf("cfg_idx[%0d]", c), 32'(index), 32'(cfg_tab[c].idx));
      check($sformatf("cfg_done_lo[%0d]", c), 32'(cfg_done), 32'd0);
    end
    @(negedge clk);
    #1;
    check("cfg_done_hi", 32'(cfg_done), 32'd1);
    check("idle_act", 32'(action), 32'(ActNone));
    check("mindex", 32'(mindex), 32'd0);
  endtask

  task automatic run_txn(input txn_t t);
    logic ok;
    int   k;
    @(negedge clk);
    tx_full  = (t.full_cyc > 0) ? 4'h1 : 4'h0;
    tx_valid = 1'b1;
    tx_data  = t.data;
    #1;
    ok = 1'b1;
    for (int j = 0; j < t.full_cyc; j++) begin
      if (tx_ready !== 1'b0 || action === ActPush) ok = 1'b0;
      @(negedge clk);
      #1;
    end
    if (t.full_cyc > 0) check("tx_bp_hold", 32'(ok), 32'd1);
    tx_full = 4'h0;
    #1;
    check("tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    #1;
    check("push_act", 32'(action), 32'(ActPush));
    check("push_din", din, {t.data, 24'h0});
    @(negedge clk);
    #1;
    if (t.delay >= 0) begin
      for (int j = 0; j < t.delay; j++) @(negedge clk);
      rx_empty = 4'hE;
      dout     = t.dout_v;
      @(negedge clk);
      rx_empty = 4'hF;
      #1;
      check("pull_act", 32'(action), 32'(ActPull));
      @(negedge clk);
      #1;
      check("capt_no_valid", 32'(rx_valid), 32'd0);
      @(negedge clk);
      #1;
    end else begin
      k  = 0;
      ok = 1'b1;
      while (rx_valid !== 1'b1 && k < 100) begin
        if (action === ActPull) ok = 1'b0;
        @(negedge clk);
        #1;
        k++;
      end
      check("timeout_latency", 32'(k), 32'd16);
      check("timeout_no_pull", 32'(ok), 32'd1);
    end
    check("rx_valid", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'(t.exp_data));
    check("rx_err", 32'(rx_err), 32'(t.exp_err));
    check("resp_tx_ready", 32'(tx_ready), 32'd0);
    ok = 1'b1;
    for (int j = 0; j < t.rx_hold; j++) begin
      @(negedge clk);
      #1;
      if (rx_valid !== 1'b1 || rx_data !== t.exp_data || rx_err !== t.exp_err ||
          tx_ready !== 1'b0) ok = 1'b0;
    end
    if (t.rx_hold > 0) check("rx_bp_hold", 32'(ok), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    check("resp_done", 32'(rx_valid), 32'd0);
    check("back_idle", 32'(tx_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_tab[0] = '{ActNone,  5'd0, 32'h0};
    cfg_tab[1] = '{ActInstr, 5'd0, 32'h00006001};
    cfg_tab[2] = '{ActNone,  5'd0, 32'h0};
    cfg_tab[3] = '{ActInstr, 5'd1, 32'h00004001};
    cfg_tab[4] = '{ActPend,  5'd0, 32'h00001000};
    cfg_tab[5] = '{ActDiv,   5'd0, 32'h00000C80};
    cfg_tab[6] = '{ActGrps,  5'd0, 32'h20100001};
    cfg_tab[7] = '{ActShift, 5'd0, 32'h10830000};
    cfg_tab[8] = '{ActEn,    5'd0, 32'h00000001};

    txn_tab[0] = '{8'h40, 0,  3, 32'h000000FF, 0,  8'hFF, 1'b0};
    txn_tab[1] = '{8'h80, 0,  0, 32'h000000FF, 0,  8'hFF, 1'b0};
    txn_tab[2] = '{8'h55, 20, 2, 32'hFFFFFF0F, 0,  8'h0F, 1'b0};
    txn_tab[3] = '{8'h3C, 0, -1, 32'h00000000, 0,  8'h00, 1'b1};
    txn_tab[4] = '{8'hA5, 0, 15, 32'h12345A5A, 10, 8'h5A, 1'b0};
    txn_tab[5] = '{8'h01, 0,  7, 32'hABCDEFC3, 0,  8'hC3, 1'b0};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    dout     = 32'h0;
    tx_full  = 4'h0;
    rx_empty = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_action", 32'(action), 32'(ActNone));

    do_config();
    for (int n = 0; n < 6; n++) run_txn(txn_tab[n]);

    // Reset while waiting for RX data: everything clears at once, then config replays.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    #1;
    check("mid_tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_action", 32'(action), 32'(ActNone));
    check("mid_rst_din", din, 32'h0);
    check("mid_rst_index", 32'(index), 32'd0);
    check("mid_rst_prog_addr", 32'(prog_addr), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_rx_data", 32'(rx_data), 32'd0);
    check("mid_rst_rx_err", 32'(rx_err), 32'd0);
    check("mid_rst_cfg_done", 32'(cfg_done), 32'd0);
    repeat (2) @(negedge clk);
    do_config();
    run_txn(txn_tab[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
